// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants for the FIFO read-side helpers
// Holds the legal read-latency range, the default word width and the
// output-buffer sizing rule used by fifo_stream_reader.
package fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int RD_LATENCY_MIN     = 1;
    localparam int RD_LATENCY_MAX     = 2;

    // One entry per in-flight read plus two, so a full read pipeline and a
    // stalled head word never starve the stream.
    function automatic int buf_depth(input int rd_latency);
        return rd_latency + 2;
    endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// rtl/fifo_stream_reader_if.sv - FIFO read port plus output stream bundle
// Signals:
//   fifo_empty / fifo_rd_en / fifo_dout : FIFO read port
//   out_data / out_valid / out_ready    : downstream valid/ready stream
// Modports:
//   master : the reader (drives fifo_rd_en and the stream)
//   slave  : the environment (FIFO and consumer)
interface fifo_stream_reader_if
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

    logic                  fifo_empty;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        input  fifo_empty,
        input  fifo_dout,
        input  out_ready,
        output fifo_rd_en,
        output out_data,
        output out_valid
    );

    modport slave (
        output fifo_empty,
        output fifo_dout,
        output out_ready,
        input  fifo_rd_en,
        input  out_data,
        input  out_valid
    );

endinterface

// File: rtl/fifo_stream_buf.sv
// rtl/fifo_stream_buf.sv - circular output buffer for fifo_stream_reader
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   flush      : synchronous drop of all entries
//   push, push_data : write one word at the tail
//   pop        : remove the head word (caller guarantees occ != 0)
//   occ        : number of stored words, 0..DEPTH
//   head_data  : word at the head
module fifo_stream_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = 3,
    localparam int PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [CW-1:0]         occ,
    output logic [DATA_WIDTH-1:0] head_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;

    // DEPTH need not be a power of two, so wrap explicitly.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - FIFO read-side master presenting a valid/ready stream
// Pops a FIFO whenever the output buffer has room for every outstanding read,
// hides the FIFO read latency and sustains one word per cycle.
// Ports:
//   clk, rst   : FIFO read clock, asynchronous active-high reset
//   bus        : fifo_stream_reader_if.master (FIFO read port + output stream)
//   flush      : one-cycle synchronous drop of buffered and in-flight words
//   busy       : buffer non-empty or reads in flight
//   rd_count   : words delivered, 16-bit wrapping (only with FIFO_RDR_CNT_EN)
// Build option: define FIFO_RDR_CNT_EN to add the rd_count port and counter.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    fifo_stream_reader_if.master bus,
    input  logic        flush,
    output logic        busy
`ifdef FIFO_RDR_CNT_EN
    ,
    output logic [15:0] rd_count
`endif
);

    localparam int BUF_DEPTH = buf_depth(RD_LATENCY);
    localparam int CW        = $clog2(BUF_DEPTH + 1);

    if (RD_LATENCY < RD_LATENCY_MIN || RD_LATENCY > RD_LATENCY_MAX) begin : g_bad_latency
        $error("fifo_stream_reader: RD_LATENCY must be 1 or 2");
    end

    logic [RD_LATENCY-1:0] inflight_sr;
    logic [CW-1:0]         inflight;
    logic [CW-1:0]         occ;
    logic                  rd_en;
    logic                  capture;
    logic                  xfer;
    logic [DATA_WIDTH-1:0] head_data;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + CW'(inflight_sr[i]);
        end
    end

    // Credit: only registered occupancy feeds this, so out_ready never
    // reaches fifo_rd_en combinationally.
    assign rd_en   = !rst && !bus.fifo_empty && !flush
                     && ((occ + inflight) < CW'(BUF_DEPTH));
    assign capture = inflight_sr[RD_LATENCY-1];
    assign xfer    = bus.out_valid && bus.out_ready;

    // Tail of this shift register lines up with fifo_dout being valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_sr <= '0;
        end else if (flush) begin
            inflight_sr <= '0;
        end else begin
            inflight_sr[0] <= rd_en;
            for (int i = 1; i < RD_LATENCY; i++) begin
                inflight_sr[i] <= inflight_sr[i-1];
            end
        end
    end

    fifo_stream_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUF_DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (capture && !flush),
        .push_data (bus.fifo_dout),
        .pop       (xfer),
        .occ       (occ),
        .head_data (head_data)
    );

    assign bus.fifo_rd_en = rd_en;
    assign bus.out_valid  = (occ != '0);
    assign bus.out_data   = head_data;
    assign busy           = (occ != '0) || (inflight != '0);

`ifdef FIFO_RDR_CNT_EN
    // A transfer in the flush cycle was seen by the consumer, so it counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_count <= '0;
        end else if (xfer) begin
            rd_count <= rd_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - self-checking bench for fifo_stream_reader (RD_LATENCY 1 and 2)
module tb_fifo_stream_reader;
    import fifo_pkg::*;

    localparam int DW = 8;
    localparam int NL = 2;

    typedef logic [DW-1:0] word_q_t [$];

    typedef struct {
        logic rst;
        logic empty;
        logic flush;
        logic exp_rd;
        logic exp_valid;
        logic exp_busy;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [NL-1:0] empty_r;
    logic [NL-1:0] ready_r;
    logic [NL-1:0] flush_r;
    logic [NL-1:0] gap_r;
    logic [DW-1:0] dout_r [NL];
    logic [NL-1:0] rd_en_w;
    logic [NL-1:0] valid_w;
    logic [NL-1:0] busy_w;
    logic [DW-1:0] data_w [NL];
`ifdef FIFO_RDR_CNT_EN
    logic [15:0]   cnt_w [NL];
`endif

    for (genvar k = 0; k < NL; k++) begin : g_lane
        fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus ();
        assign bus.fifo_empty = empty_r[k];
        assign bus.fifo_dout  = dout_r[k];
        assign bus.out_ready  = ready_r[k];
        assign rd_en_w[k]     = bus.fifo_rd_en;
        assign valid_w[k]     = bus.out_valid;
        assign data_w[k]      = bus.out_data;

        fifo_stream_reader #(
            .DATA_WIDTH (DW),
            .RD_LATENCY (k + 1)
        ) dut (
            .clk      (clk),
            .rst      (rst),
            .bus      (bus),
            .flush    (flush_r[k]),
            .busy     (busy_w[k])
`ifdef FIFO_RDR_CNT_EN
            ,
            .rd_count (cnt_w[k])
`endif
        );
    end

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Reference model: FIFO contents, words popped but not yet delivered.
    word_q_t       fq [NL];
    word_q_t       sb [NL];
    logic [DW-1:0] dly [NL];
    logic [NL-1:0] dly_v;
    logic [NL-1:0] hold;
    logic [DW-1:0] hold_d [NL];

    logic [NL-1:0] s_rd, s_v, s_r, s_f, s_busy;
    logic [DW-1:0] s_d [NL];

    int pops [NL];
    int xfers [NL];
    int first_rd [NL];
    int first_v [NL];
    int last_x [NL];

    task automatic check(input string name, input int lane, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s lane%0d cycle %0d: got %0h, expected %0h", name, lane, cyc, act, exp);
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        ready_r = '0;
        flush_r = '0;
        gap_r   = '0;
        empty_r = '1;
        dly_v   = '0;
        hold    = '0;
        for (int k = 0; k < NL; k++) begin
            fq[k].delete();
            sb[k].delete();
            dout_r[k]   = '0;
            pops[k]     = 0;
            xfers[k]    = 0;
            first_rd[k] = -1;
            first_v[k]  = -1;
            last_x[k]   = -1;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    // One clock: inputs set by the caller, sample at negedge, advance model after posedge.
    task automatic step();
        for (int k = 0; k < NL; k++) begin
            empty_r[k] = (fq[k].size() == 0) || gap_r[k];
        end
        @(negedge clk);
        for (int k = 0; k < NL; k++) begin
            s_rd[k]   = rd_en_w[k];
            s_v[k]    = valid_w[k];
            s_d[k]    = data_w[k];
            s_r[k]    = ready_r[k];
            s_f[k]    = flush_r[k];
            s_busy[k] = busy_w[k];
            if (s_rd[k]) begin
                check("rd_en_while_empty", k, 32'(empty_r[k]), 0);
                check("rd_en_during_flush", k, 32'(flush_r[k]), 0);
                pops[k]++;
                if (first_rd[k] < 0) first_rd[k] = cyc;
            end
            if (hold[k]) begin
                check("hold_valid", k, 32'(s_v[k]), 1);
                check("hold_data", k, 32'(s_d[k]), 32'(hold_d[k]));
            end
            if (s_v[k] && first_v[k] < 0) first_v[k] = cyc;
            if (s_v[k] && s_r[k]) begin
                if (sb[k].size() == 0) check("xfer_with_nothing_outstanding", k, 0, 1);
                else check("xfer_data", k, 32'(s_d[k]), 32'(sb[k].pop_front()));
                xfers[k]++;
                last_x[k] = cyc;
            end
            hold[k]   = s_v[k] && !s_r[k] && !s_f[k];
            hold_d[k] = s_d[k];
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < NL; k++) begin
            logic [DW-1:0] w;
            w = DW'($urandom);
            if (s_rd[k]) begin
                if (fq[k].size() > 0) w = fq[k].pop_front();
                sb[k].push_back(w);
            end
            if (s_f[k]) sb[k].delete();
            if (k == 0) begin
                dout_r[k] = s_rd[k] ? w : DW'($urandom);
            end else begin
                dout_r[k] = dly_v[k] ? dly[k] : DW'($urandom);
                dly[k]    = w;
                dly_v[k]  = s_rd[k];
            end
            check("occ_bound", k, (sb[k].size() > buf_depth(k + 1)) ? 1 : 0, 0);
        end
        cyc++;
    endtask

    vec_t tbl [11];
    int   fc [NL];
    logic [DW-1:0] nxt [NL];
    logic [NL-1:0] got;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          rst   empty flush rd    valid busy
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        do_reset();
        rst = 1'b1;

        // Reset, credit gating and flush of an in-flight read, applied directly.
        for (int i = 0; i < 11; i++) begin
            rst     = tbl[i].rst;
            empty_r = {NL{tbl[i].empty}};
            flush_r = {NL{tbl[i].flush}};
            @(negedge clk);
            for (int k = 0; k < NL; k++) begin
                check($sformatf("tbl%0d_rd_en", i), k, 32'(rd_en_w[k]), 32'(tbl[i].exp_rd));
                check($sformatf("tbl%0d_valid", i), k, 32'(valid_w[k]), 32'(tbl[i].exp_valid));
                check($sformatf("tbl%0d_busy", i), k, 32'(busy_w[k]), 32'(tbl[i].exp_busy));
            end
            @(posedge clk);
            #1;
        end
        for (int k = 0; k < NL; k++) check("reset_out_data", k, 32'(data_w[k]), 0);

        // Back-to-back stream of 0x01..0x10.
        do_reset();
        for (int k = 0; k < NL; k++) for (int i = 1; i <= 16; i++) fq[k].push_back(DW'(i));
        ready_r = '1;
        repeat (40) step();
        for (int k = 0; k < NL; k++) begin
            check("stream_xfers", k, 32'(xfers[k]), 16);
            check("first_valid_latency", k, 32'(first_v[k] - first_rd[k]), 32'(k + 2));
            check("back_to_back", k, 32'(last_x[k] - first_v[k]), 15);
        end

        // Stalled consumer: exactly BUF_DEPTH pops, head held.
        do_reset();
        for (int k = 0; k < NL; k++) for (int i = 1; i <= 16; i++) fq[k].push_back(DW'(i));
        repeat (10) step();
        for (int k = 0; k < NL; k++) begin
            check("stall_pops", k, 32'(pops[k]), 32'(buf_depth(k + 1)));
            check("stall_rd_en_low", k, 32'(s_rd[k]), 0);
            check("stall_valid", k, 32'(valid_w[k]), 1);
            check("stall_head", k, 32'(data_w[k]), 1);
        end
        ready_r = '1;
        repeat (30) step();
        for (int k = 0; k < NL; k++) check("stall_drain_xfers", k, 32'(xfers[k]), 16);

        // Random backpressure and FIFO empty gaps.
        do_reset();
        for (int k = 0; k < NL; k++) for (int i = 0; i < 256; i++) fq[k].push_back(DW'($urandom));
        for (int c = 0; c < 4000; c++) begin
            if (xfers[0] >= 256 && xfers[1] >= 256) break;
            for (int k = 0; k < NL; k++) begin
                ready_r[k] = ($urandom_range(0, 3) != 0);
                gap_r[k]   = ($urandom_range(0, 3) == 0);
            end
            step();
        end
        for (int k = 0; k < NL; k++) check("random_xfers", k, 32'(xfers[k]), 256);

        // Flush with a full buffer and one read in flight.
        do_reset();
        fc[0] = 3;
        fc[1] = 5;
        got   = '0;
        for (int k = 0; k < NL; k++) for (int i = 0; i < 16; i++) fq[k].push_back(DW'(8'h40 + i));
        for (int c = 0; c < 30; c++) begin
            for (int k = 0; k < NL; k++) begin
                flush_r[k] = (c == fc[k]);
                ready_r[k] = (c > fc[k] + 1);
            end
            step();
            for (int k = 0; k < NL; k++) begin
                if (c == fc[k]) begin
                    check("pre_flush_valid", k, 32'(s_v[k]), 1);
                    check("pre_flush_head", k, 32'(s_d[k]), 32'h40);
                    nxt[k] = fq[k][0];
                end
                if (c == fc[k] + 1) begin
                    check("post_flush_valid", k, 32'(s_v[k]), 0);
                    check("post_flush_busy", k, 32'(s_busy[k]), 0);
                end
                if (c > fc[k] + 1 && !got[k] && s_v[k] && s_r[k]) begin
                    check("post_flush_next_word", k, 32'(s_d[k]), 32'(nxt[k]));
                    got[k] = 1'b1;
                end
            end
        end
        for (int k = 0; k < NL; k++) check("post_flush_seen", k, 32'(got[k]), 1);

`ifdef FIFO_RDR_CNT_EN
        // Delivered-word counter wraps at 16 bits and ignores flush.
        do_reset();
        for (int c = 0; c < 75000; c++) begin
            if (xfers[0] >= 70000 && xfers[1] >= 70000) break;
            for (int k = 0; k < NL; k++) begin
                while (fq[k].size() < 8) fq[k].push_back(DW'($urandom));
                ready_r[k] = (xfers[k] < 70000);
            end
            step();
        end
        ready_r = '0;
        repeat (2) step();
        for (int k = 0; k < NL; k++) check("rd_count_wrap", k, 32'(cnt_w[k]), 4464);
        flush_r = '1;
        step();
        flush_r = '0;
        step();
        for (int k = 0; k < NL; k++) check("rd_count_after_flush", k, 32'(cnt_w[k]), 4464);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
